text_bounce_ctrl: RTL and testbench
===================================

# text_bounce_ctrl

Frame-rate motion controller for on-screen text. It produces the top-left `x_pos`/`y_pos` and a `visible` gate for a string renderer, and sits directly upstream of the string display stage. After a start pulse it blinks the text in place, then bounces it horizontally between two limits, pausing at each end. Position updates happen only on the frame tick, so the string never moves mid-scan.

## Interface
- `X_MIN`, default 0: left limit of `x_pos` in pixels.
- `X_MAX`, default 528: right limit of `x_pos` (640 minus the 112-pixel string width).
- `Y_POS`, default 224: constant vertical position.
- `STEP`, default 2: pixels moved per frame tick while scrolling.
- `PAUSE_FRAMES`, default 30: frame ticks to dwell at each limit.
- `BLINK_HALF`, default 15: frame ticks per visible/invisible half-period.
- `BLINK_COUNT`, default 3: number of off/on blink cycles before scrolling. 0 skips blinking.

Ports:
- `clk_0`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse, once per frame, during vertical blanking.
- `start`, in, 1: one-cycle pulse that begins the sequence.
- `stop`, in, 1: one-cycle pulse that aborts to idle.
- `x_pos`, out, 10: top-left X of the string.
- `y_pos`, out, 10: top-left Y of the string, always `Y_POS`.
- `visible`, out, 1: text enable, ANDed with the renderer's `pixel_on` downstream.
- `dir`, out, 1: scroll direction. 0 = rightward, 1 = leftward.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, BLINK, SCROLL, PAUSE.
- Reset (`rst` = 0) puts the block in IDLE with `x_pos` = `X_MIN`, `y_pos` = `Y_POS`, `visible` = 1, `dir` = 0, `busy` = 0, and all counters at 0.
- IDLE:
  - Outputs hold.
  - `start` goes to BLINK (or to SCROLL if `BLINK_COUNT` = 0).
  - On entering BLINK: `visible` = 0, frame counter = 0, toggle counter = 0.
- BLINK:
  - Each `frame_tick` increments the frame counter.
  - On the tick where the frame counter equals `BLINK_HALF`-1: toggle `visible`, clear the frame counter, increment the toggle counter.
  - After 2×`BLINK_COUNT` toggles (`visible` is back at 1), go to SCROLL.
  - `x_pos` holds throughout.
- SCROLL, on each `frame_tick`:
  - `dir` = 0: if `x_pos`+`STEP` ≥ `X_MAX`, then `x_pos` = `X_MAX` and go to PAUSE; else `x_pos` += `STEP`.
  - `dir` = 1: if `x_pos` ≤ `X_MIN`+`STEP`, then `x_pos` = `X_MIN` and go to PAUSE; else `x_pos` -= `STEP`.
  - Comparisons are computed at 11 bits so there is no 10-bit wrap. `x_pos` never leaves [`X_MIN`, `X_MAX`].
- PAUSE:
  - Counts `frame_tick`s.
  - On the `PAUSE_FRAMES`-th tick: invert `dir`, clear the counter, go to SCROLL.
- `stop` in any non-IDLE state:
  - Next state is IDLE with `visible` = 1.
  - `x_pos` and `dir` hold their current values.
  - Counters clear.
- Priority rules:
  - `stop` beats `start` in the same cycle.
  - `stop` beats `frame_tick` in the same cycle: no motion and no count.
  - `start` while `busy` is ignored.
  - A `frame_tick` coincident with `start` in IDLE is not counted in BLINK.
- A restart after `stop` resumes from the held `x_pos` and `dir`. If `x_pos` is already at a limit, the first SCROLL tick clamps and enters PAUSE.
- Parameter rules: `X_MAX` > `X_MIN`, `STEP` ≥ 1, `PAUSE_FRAMES` ≥ 1, `BLINK_HALF` ≥ 1, all limits < 1024.

## Timing
- All outputs are registered. Each changes exactly one `clk_0` cycle after the qualifying `frame_tick`, `start`, or `stop` edge.
- No combinational path from any input to any output.
- `busy` rises one cycle after `start` and falls one cycle after `stop`.
- `frame_tick` pulses longer than one cycle are a protocol violation; each high cycle counts as a tick.
- Reset is asynchronous: outputs take their reset values immediately on `rst` falling, including mid-BLINK or mid-SCROLL. Release is synchronous to `clk_0` through the existing reset synchroniser.
- Default sequence length from `start`:
  - BLINK: 90 ticks.
  - Rightward scroll: 264 ticks, reaching `x_pos` = 528.
  - PAUSE: 30 ticks.
  - Then leftward.

## Test plan
- **Reset defaults:** assert `rst` low mid-SCROLL at `x_pos` = 100 → `x_pos` = 0, `visible` = 1, `busy` = 0, `dir` = 0 without waiting for a clock edge.
- **Blink sequence:** `start`, then 90 ticks → `visible` pattern 0 (15 ticks), 1, 0, 1, 0, 1. `x_pos` stays 0. First move to `x_pos` = 2 on tick 91.
- **Full bounce:** after blink, 264 ticks → `x_pos` = 528 and state PAUSE. 30 more ticks → `dir` = 1. Next tick → `x_pos` = 526.
- **Clamp with odd step:** `STEP` = 5, `X_MAX` = 528, start from 525 → next tick gives `x_pos` = 528 (not 530) and PAUSE. Leftward from 3 with `X_MIN` = 0 → `x_pos` = 0, no wrap to 1022.
- **Simultaneous events:**
  - `start` + `stop` in IDLE → stays IDLE, `busy` = 0.
  - `stop` + `frame_tick` at `x_pos` = 200 → IDLE, `x_pos` = 200.
  - `start` while busy → no state change.
- **Restart and zero blink:** `BLINK_COUNT` = 0, `start` → first tick moves `x_pos` 0→2. `stop` at 50, then `start` → resumes 50→52 with `dir` unchanged.

Source files
------------

// File: rtl/text_bounce_ctrl.sv
// Frame-rate motion controller for on-screen text: blinks the string in place after start,
// then bounces it horizontally between X_MIN and X_MAX, dwelling at each limit.
module text_bounce_ctrl #(
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 528,
   parameter int Y_POS        = 224,
   parameter int STEP         = 2,
   parameter int PAUSE_FRAMES = 30,
   parameter int BLINK_HALF   = 15,
   parameter int BLINK_COUNT  = 3
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       stop,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       visible,
   output logic       dir,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, BLINK, SCROLL, PAUSE} state_t;

   localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
   localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
   localparam logic [10:0] STEP_W     = 11'(STEP);
   localparam logic [10:0] HALF_LAST  = 11'(BLINK_HALF - 1);
   localparam logic [10:0] HALF_TOTAL = 11'(2 * BLINK_COUNT);
   localparam logic [10:0] PAUSE_LAST = 11'(PAUSE_FRAMES - 1);

   state_t      state_reg, state_next;
   logic [9:0]  x_reg, x_next;
   logic        visible_reg, visible_next;
   logic        dir_reg, dir_next;
   logic        busy_reg, busy_next;
   logic [10:0] frame_cnt_reg, frame_cnt_next;
   logic [10:0] toggle_cnt_reg, toggle_cnt_next;
   logic [10:0] pause_cnt_reg, pause_cnt_next;

   // Position arithmetic is one bit wider than x_pos so limit tests never wrap.
   logic [10:0] x_wide;
   logic        right_hit, left_hit;

   assign x_wide    = {1'b0, x_reg};
   assign right_hit = (x_wide + STEP_W) >= X_MAX_W;
   assign left_hit  = x_wide <= (X_MIN_W + STEP_W);

   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         x_reg          <= 10'(X_MIN);
         visible_reg    <= 1'b1;
         dir_reg        <= 1'b0;
         busy_reg       <= 1'b0;
         frame_cnt_reg  <= '0;
         toggle_cnt_reg <= '0;
         pause_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         visible_reg    <= visible_next;
         dir_reg        <= dir_next;
         busy_reg       <= busy_next;
         frame_cnt_reg  <= frame_cnt_next;
         toggle_cnt_reg <= toggle_cnt_next;
         pause_cnt_reg  <= pause_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      x_next          = x_reg;
      visible_next    = visible_reg;
      dir_next        = dir_reg;
      frame_cnt_next  = frame_cnt_reg;
      toggle_cnt_next = toggle_cnt_reg;
      pause_cnt_next  = pause_cnt_reg;

      if (state_reg != IDLE && stop) begin
         state_next      = IDLE;
         visible_next    = 1'b1;
         frame_cnt_next  = '0;
         toggle_cnt_next = '0;
         pause_cnt_next  = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && !stop) begin
                  frame_cnt_next  = '0;
                  toggle_cnt_next = '0;
                  pause_cnt_next  = '0;
                  if (BLINK_COUNT == 0) begin
                     state_next = SCROLL;
                  end else begin
                     state_next   = BLINK;
                     visible_next = 1'b0;
                  end
               end
            end
            BLINK: begin
               if (frame_tick) begin
                  if (frame_cnt_reg == HALF_LAST) begin
                     frame_cnt_next  = '0;
                     toggle_cnt_next = toggle_cnt_reg + 11'd1;
                     // The last half-period ends with the text shown; leave it on and start moving.
                     if (toggle_cnt_reg + 11'd1 == HALF_TOTAL) begin
                        state_next      = SCROLL;
                        visible_next    = 1'b1;
                        toggle_cnt_next = '0;
                     end else begin
                        visible_next = ~visible_reg;
                     end
                  end else begin
                     frame_cnt_next = frame_cnt_reg + 11'd1;
                  end
               end
            end
            SCROLL: begin
               if (frame_tick) begin
                  if (!dir_reg) begin
                     if (right_hit) begin
                        x_next     = 10'(X_MAX);
                        state_next = PAUSE;
                     end else begin
                        x_next = 10'(x_wide + STEP_W);
                     end
                  end else begin
                     if (left_hit) begin
                        x_next     = 10'(X_MIN);
                        state_next = PAUSE;
                     end else begin
                        x_next = 10'(x_wide - STEP_W);
                     end
                  end
               end
            end
            PAUSE: begin
               if (frame_tick) begin
                  if (pause_cnt_reg == PAUSE_LAST) begin
                     pause_cnt_next = '0;
                     dir_next       = ~dir_reg;
                     state_next     = SCROLL;
                  end else begin
                     pause_cnt_next = pause_cnt_reg + 11'd1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end

      busy_next = (state_next != IDLE);
   end

   assign x_pos   = x_reg;
   assign y_pos   = 10'(Y_POS);
   assign visible = visible_reg;
   assign dir     = dir_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_text_bounce_ctrl.sv
// Directed bench for text_bounce_ctrl: default, odd-step and no-blink instances,
// each driven through hand-computed blink, bounce, clamp, stop and reset scenarios.
module tb_text_bounce_ctrl;

   logic clk;
   logic rst;
   logic tick_d, start_d, stop_d;
   logic tick_s, start_s, stop_s;
   logic tick_b, start_b, stop_b;
   logic [9:0] x_d, y_d, x_s, y_s, x_b, y_b;
   logic vis_d, dir_d, busy_d;
   logic vis_s, dir_s, busy_s;
   logic vis_b, dir_b, busy_b;

   int checks = 0;
   int errors = 0;

   text_bounce_ctrl dut_def (
      .clk_0(clk), .rst(rst), .frame_tick(tick_d), .start(start_d), .stop(stop_d),
      .x_pos(x_d), .y_pos(y_d), .visible(vis_d), .dir(dir_d), .busy(busy_d)
   );

   text_bounce_ctrl #(.STEP(5), .PAUSE_FRAMES(2), .BLINK_COUNT(0)) dut_s5 (
      .clk_0(clk), .rst(rst), .frame_tick(tick_s), .start(start_s), .stop(stop_s),
      .x_pos(x_s), .y_pos(y_s), .visible(vis_s), .dir(dir_s), .busy(busy_s)
   );

   text_bounce_ctrl #(.BLINK_COUNT(0)) dut_b0 (
      .clk_0(clk), .rst(rst), .frame_tick(tick_b), .start(start_b), .stop(stop_b),
      .x_pos(x_b), .y_pos(y_b), .visible(vis_b), .dir(dir_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
      $display("check %-16s observed %0d", tag, obs);
   endtask

   task automatic clear_inputs();
      tick_d = 0; start_d = 0; stop_d = 0;
      tick_s = 0; start_s = 0; stop_s = 0;
      tick_b = 0; start_b = 0; stop_b = 0;
   endtask

   // One cycle of combined start/stop/tick on the chosen instance, then one idle cycle edge.
   task automatic strobe(input int which, input logic s_start, input logic s_stop, input logic s_tick);
      @(negedge clk);
      case (which)
         0: begin start_d = s_start; stop_d = s_stop; tick_d = s_tick; end
         1: begin start_s = s_start; stop_s = s_stop; tick_s = s_tick; end
         default: begin start_b = s_start; stop_b = s_stop; tick_b = s_tick; end
      endcase
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic ticks(input int which, input int n);
      for (int i = 0; i < n; i++) strobe(which, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_x", 32'(x_d), 0);
      check("rst_y", 32'(y_d), 224);
      check("rst_visible", 32'(vis_d), 1);
      check("rst_busy", 32'(busy_d), 0);
      check("rst_dir_b0", 32'(dir_b), 0);
      rst = 1'b1;

      // Blink sequence on the default instance
      strobe(0, 1'b1, 1'b0, 1'b0);
      check("start_busy", 32'(busy_d), 1);
      check("start_vis", 32'(vis_d), 0);
      ticks(0, 14);
      check("blink_t14_vis", 32'(vis_d), 0);
      ticks(0, 1);
      check("blink_t15_vis", 32'(vis_d), 1);
      for (int h = 2; h <= 6; h++) begin
         ticks(0, 15);
         check($sformatf("blink_h%0d_vis", h), 32'(vis_d), ((h % 2 == 1) || (h == 6)) ? 1 : 0);
      end
      check("blink_end_x", 32'(x_d), 0);
      ticks(0, 1);
      check("scroll_t91_x", 32'(x_d), 2);

      // Full rightward run, pause, then leftward
      ticks(0, 263);
      check("right_end_x", 32'(x_d), 528);
      check("right_end_dir", 32'(dir_d), 0);
      ticks(0, 29);
      check("pause29_x", 32'(x_d), 528);
      check("pause29_dir", 32'(dir_d), 0);
      ticks(0, 1);
      check("pause30_dir", 32'(dir_d), 1);
      ticks(0, 1);
      check("left_first_x", 32'(x_d), 526);
      ticks(0, 213);
      check("left_x100", 32'(x_d), 100);

      // Asynchronous reset in the middle of a clock period
      #2 rst = 1'b0;
      #1;
      check("arst_x", 32'(x_d), 0);
      check("arst_visible", 32'(vis_d), 1);
      check("arst_busy", 32'(busy_d), 0);
      check("arst_dir", 32'(dir_d), 0);
      @(negedge clk);
      rst = 1'b1;

      // start while busy must not restart the blink counter
      strobe(0, 1'b1, 1'b0, 1'b0);
      ticks(0, 5);
      strobe(0, 1'b1, 1'b0, 1'b0);
      check("restart_busy", 32'(busy_d), 1);
      ticks(0, 9);
      check("restart_t14_vis", 32'(vis_d), 0);
      ticks(0, 1);
      check("restart_t15_vis", 32'(vis_d), 1);
      strobe(0, 1'b0, 1'b1, 1'b0);
      check("stop_busy", 32'(busy_d), 0);
      check("stop_vis", 32'(vis_d), 1);
      strobe(0, 1'b1, 1'b1, 1'b0);
      check("start_stop_busy", 32'(busy_d), 0);
      @(negedge clk);
      check("start_stop_hold", 32'(busy_d), 0);

      // Odd step: clamp on both sides
      strobe(1, 1'b1, 1'b0, 1'b0);
      check("s5_busy", 32'(busy_s), 1);
      check("s5_vis", 32'(vis_s), 1);
      ticks(1, 105);
      check("s5_x525", 32'(x_s), 525);
      ticks(1, 1);
      check("s5_clamp_528", 32'(x_s), 528);
      ticks(1, 1);
      check("s5_pause_x", 32'(x_s), 528);
      check("s5_pause_dir", 32'(dir_s), 0);
      ticks(1, 1);
      check("s5_turn_dir", 32'(dir_s), 1);
      ticks(1, 105);
      check("s5_x3", 32'(x_s), 3);
      ticks(1, 1);
      check("s5_clamp_0", 32'(x_s), 0);
      ticks(1, 1);
      check("s5_hold_0", 32'(x_s), 0);
      check("s5_busy_pause", 32'(busy_s), 1);

      // Zero blink count, stop/restart, stop coincident with tick
      strobe(2, 1'b1, 1'b0, 1'b0);
      check("b0_busy", 32'(busy_b), 1);
      ticks(2, 1);
      check("b0_first_x", 32'(x_b), 2);
      ticks(2, 24);
      check("b0_x50", 32'(x_b), 50);
      strobe(2, 1'b0, 1'b1, 1'b0);
      check("b0_stop_busy", 32'(busy_b), 0);
      check("b0_stop_x", 32'(x_b), 50);
      strobe(2, 1'b1, 1'b0, 1'b0);
      ticks(2, 1);
      check("b0_resume_x", 32'(x_b), 52);
      check("b0_resume_dir", 32'(dir_b), 0);
      ticks(2, 74);
      check("b0_x200", 32'(x_b), 200);
      strobe(2, 1'b0, 1'b1, 1'b1);
      check("b0_stoptick_x", 32'(x_b), 200);
      check("b0_stoptick_busy", 32'(busy_b), 0);
      check("b0_stoptick_vis", 32'(vis_b), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
